// File: rtl/q6_fb_glitch_filter.sv
// ----------------------------------------------------------------------------
// q6_fb_glitch_filter
//
// Deglitcher and hazard monitor for the q6_FB static-hazard circuit output.
// The raw `din` is brought into the clock domain through a two-flop
// synchronizer. The filtered level `dout` follows the synchronized sample
// only after the sample has differed from `dout` for STABLE_CYCLES
// consecutive cycles. Any shorter excursion is rejected. Each rejection is
// counted, and its width is recorded.
//
// Parameters:
//   STABLE_CYCLES  consecutive differing samples needed to change dout (2..255)
//   CNT_W          width of glitch_cnt
//   RESET_VAL      reset level of the synchronizer flops and dout
//
// Ports:
//   clk         rising-edge clock, the only clock of the block
//   rst_n       synchronous active-low reset
//   din         raw q6_FB output, asynchronous to clk
//   clr         synchronous clear of glitch_cnt and last_width
//   dout        filtered level
//   rise        one-cycle pulse on the cycle dout goes 0->1
//   fall        one-cycle pulse on the cycle dout goes 1->0
//   glitch      one-cycle pulse on the cycle a rejected excursion ends
//   glitch_cnt  saturating count of rejected excursions
//   last_width  width in samples of the most recent rejected excursion
// ----------------------------------------------------------------------------
module q6_fb_glitch_filter #(
    parameter int   STABLE_CYCLES = 4,
    parameter int   CNT_W         = 8,
    parameter logic RESET_VAL     = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din,
    input  logic             clr,
    output logic             dout,
    output logic             rise,
    output logic             fall,
    output logic             glitch,
    output logic [CNT_W-1:0] glitch_cnt,
    output logic [7:0]       last_width
);

    localparam int            QW     = $clog2(STABLE_CYCLES + 1);
    localparam logic [QW-1:0] Q_ONE  = QW'(1);
    localparam logic [QW-1:0] Q_LAST = QW'(STABLE_CYCLES - 1);

    typedef enum logic {
        ST_STABLE,
        ST_QUAL
    } state_t;

    state_t            state, state_n;
    logic [QW-1:0]     q, q_n;
    logic              s1, s;
    logic              dout_n, rise_n, fall_n, glitch_n;
    logic [CNT_W-1:0]  cnt_n;
    logic [7:0]        width_n;

    // ------------------------------------------------------------------
    // Next-state and next-output logic. Only the second synchronizer
    // stage `s` is used here, because `s1` may still be metastable.
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default first, so no path through the
        // case/if tree can leave a value unassigned and infer a latch.
        state_n  = state;
        q_n      = q;
        dout_n   = dout;
        rise_n   = 1'b0;
        fall_n   = 1'b0;
        glitch_n = 1'b0;
        cnt_n    = glitch_cnt;
        width_n  = last_width;

        unique case (state)
            ST_STABLE: begin
                q_n = '0;
                if (s != dout) begin
                    // This is the first differing sample, so it counts as one.
                    state_n = ST_QUAL;
                    q_n     = Q_ONE;
                end
            end

            ST_QUAL: begin
                if (s != dout) begin
                    if (q == Q_LAST) begin
                        // The sample now counted is number STABLE_CYCLES,
                        // so the new level is accepted.
                        dout_n  = s;
                        rise_n  = s;
                        fall_n  = ~s;
                        q_n     = '0;
                        state_n = ST_STABLE;
                    end else begin
                        q_n = q + Q_ONE;
                    end
                end else begin
                    // The level returned before it qualified. q holds how
                    // many differing samples were seen.
                    glitch_n = 1'b1;
                    width_n  = 8'(q);
                    if (glitch_cnt != '1) begin
                        cnt_n = glitch_cnt + 1'b1;
                    end
                    q_n     = '0;
                    state_n = ST_STABLE;
                end
            end

            default: begin
                state_n = ST_STABLE;
                q_n     = '0;
            end
        endcase

        // A clear overrides a rejection in the same cycle. The glitch pulse
        // above is left alone, so the event is still reported.
        if (clr) begin
            cnt_n   = '0;
            width_n = '0;
        end
    end

    // ------------------------------------------------------------------
    // Registers. Reset is synchronous. Every output is driven from a flop.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments, so each flop
        // samples the values from before the edge, whatever the statement order.
        if (!rst_n) begin
            s1         <= RESET_VAL;
            s          <= RESET_VAL;
            dout       <= RESET_VAL;
            state      <= ST_STABLE;
            q          <= '0;
            rise       <= 1'b0;
            fall       <= 1'b0;
            glitch     <= 1'b0;
            glitch_cnt <= '0;
            last_width <= '0;
        end else begin
            s1         <= din;
            s          <= s1;
            dout       <= dout_n;
            state      <= state_n;
            q          <= q_n;
            rise       <= rise_n;
            fall       <= fall_n;
            glitch     <= glitch_n;
            glitch_cnt <= cnt_n;
            last_width <= width_n;
        end
    end

endmodule

// File: doc/q6_fb_glitch_filter.md
# q6_fb_glitch_filter

Synchronous deglitcher and hazard monitor placed directly downstream of the q6_FB static-hazard circuit. It samples the combinational `out` signal through a two-flop synchronizer and publishes a filtered level only after it has held for a programmable number of cycles. It counts every rejected excursion, which quantifies the static-1 hazard on the 011 -> 010 transition before and after the a&~b consensus-term correction.

## Interface

Parameters:
- STABLE_CYCLES, 4, consecutive differing samples required before `dout` changes; legal range 2..255
- CNT_W, 8, width of `glitch_cnt`
- RESET_VAL, 1'b1, reset level of the synchronizer flops and `dout`; matches the q6_FB output for abc=000

Ports:
- clk  input  1  rising-edge clock; this is the single clock of the block
- rst_n  input  1  reset, synchronous, active-low
- din  input  1  raw q6_FB `out`; asynchronous to clk
- clr  input  1  synchronous clear of `glitch_cnt` and `last_width`
- dout  output  1  filtered level
- rise  output  1  one-cycle pulse on the cycle `dout` goes 0->1
- fall  output  1  one-cycle pulse on the cycle `dout` goes 1->0
- glitch  output  1  one-cycle pulse on the cycle a rejected excursion ends
- glitch_cnt  output  CNT_W  saturating count of rejected excursions
- last_width  output  8  width in samples of the most recent rejected excursion

## Operation

- Synchronizer: `s1 <= din`, `s <= s1`. Only `s` feeds the logic.
- Qualify counter `q` has width clog2(STABLE_CYCLES+1).
- STABLE state:
  - If `s == dout`, stay in STABLE with `q = 0`.
  - If `s != dout`, go to QUAL with `q <= 1`.
- QUAL state, when `s != dout`:
  - If `q == STABLE_CYCLES-1`, set `dout <= s`, pulse `rise` or `fall`, set `q <= 0`, and go to STABLE.
  - Otherwise set `q <= q+1`.
- QUAL state, when `s == dout` (rejection):
  - Pulse `glitch`.
  - Set `last_width <= q`.
  - Increment `glitch_cnt`, saturating at all-ones.
  - Set `q <= 0` and go to STABLE.
- `clr` takes priority over a simultaneous glitch increment. In that cycle `glitch_cnt` and `last_width` become 0, and the `glitch` pulse still fires.
- A glitch narrower than one clock period can fall between sampling edges. Such a glitch is neither seen nor counted, by design.
- Reset (rst_n low at a clock edge) sets:
  - `s1`, `s`, `dout` to RESET_VAL
  - state to STABLE, `q` to 0
  - `rise`, `fall`, `glitch` to 0
  - `glitch_cnt`, `last_width` to 0
- Reset asserted mid-QUAL abandons the pending qualification. No pulse is produced and no count is recorded.
- `dout` never toggles more than once per STABLE_CYCLES cycles.

## Timing

- All outputs are registered. No combinational path runs from `din` to any output.
- Level-change latency: let E0 be the first clk edge that captures a new `din` level into `s1`. `dout`, and the matching `rise` or `fall`, update at edge E0+STABLE_CYCLES+1. With the default this is E0+5.
- Rejection latency: `glitch` asserts at the edge that registers the first `s` sample equal to `dout` again. That is edge E0+W+2 for an excursion captured for W samples, where W < STABLE_CYCLES.
- `rise`, `fall` and `glitch` are mutually exclusive in any cycle.
- Each pulse is high for exactly one cycle.
- Back-to-back excursions separated by one good sample are counted separately.

## Test plan

- Reset: hold rst_n=0 for 3 cycles with din=0 -> `dout`=1, `glitch_cnt`=0, all pulses 0. After release, `fall` occurs exactly 5 edges after the first capturing edge.
- Clean transition: din 1->0 held for 10 cycles -> one `fall` pulse at E0+5, `dout`=0, `glitch_cnt` unchanged.
- Hazard capture:
  - Stimulus: drive q6_FB with abc 011->010 at a 10 ns clock, uncorrected circuit, NOT-gate delay stretched to 25 ns.
  - Required: `glitch` fires once, `last_width`=2 or 3, `dout` stays 1.
  - Repeat with the a&~b term added: no `glitch`, `glitch_cnt` unchanged.
- Threshold boundary:
  - A 3-sample low pulse -> `glitch`, `last_width`=3.
  - A 4-sample low pulse -> `fall` then `rise`, `glitch_cnt` unchanged.
- Saturation and clear:
  - Run 300 one-sample pulses with CNT_W=8 -> `glitch_cnt`=255.
  - Assert `clr` in the same cycle as a `glitch` -> `glitch_cnt`=0.
- Reset mid-QUAL: drop din for 2 samples, then pulse rst_n low for 1 cycle -> no `glitch`, `glitch_cnt`=0, `dout`=1.
